regfile_sequencer: RTL and testbench

Drives the 8×8 register file's write and dual-read ports from a simple instruction handshake. The block accepts one three-operand instruction at a time, reads two source registers, computes an 8-bit ALU result and writes it back. It sits between the instruction decoder and the register file. It is the only master of the register file's address, data and write-enable pins.

---
 rtl/regfile_seq_pkg.sv | 27 ++
 rtl/regfile_seq_alu.sv | 50 +++++
 rtl/regfile_sequencer.sv | 144 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg
// Shared definitions for the register-file sequencer: default widths,
// opcode encoding and the FSM state encoding.
package regfile_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MOV = 3'd5,
    OP_LDI = 3'd6,
    OP_NOP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// regfile_seq_alu
// Purely combinational 8-op ALU used by the sequencer in its EXEC cycle.
// Ports:
//   op_i     - opcode
//   a_i/b_i  - source operands (unsigned)
//   imm_i    - immediate, used by LDI only
//   result_o - DATA_W-bit result, modulo 2^DATA_W
//   carry_o  - ADD carry-out, SUB borrow (a < b), 0 for every other op
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum_w;
  logic [DATA_W:0] diff_w;

  // Zero-extended by one bit so the top bit is carry (sum) or borrow (diff).
  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_w = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum_w[DATA_W-1:0];
        carry_o  = sum_w[DATA_W];
      end
      OP_SUB: begin
        result_o = diff_w[DATA_W-1:0];
        carry_o  = diff_w[DATA_W];
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_MOV:  result_o = a_i;
      OP_LDI:  result_o = imm_i;
      default: result_o = '0;  // NOP produces a zero result, no carry
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
// Accepts one three-operand instruction at a time over a valid/ready
// handshake, reads two source registers from an external register file,
// computes the ALU result and writes it back.  Four-cycle sequence:
// IDLE -> READ -> EXEC -> WB.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   instr_valid/ready     - instruction handshake (ready only in IDLE)
//   instr_op/rd/ra/rb/imm - instruction fields, sampled on acceptance
//   RdAdrsA/B, RdDataA/B  - register file read ports
//   WtAdrs, WtData, LdReg - register file write port
//   done                  - one-cycle pulse during writeback
//   result, flag_z/flag_c - last computed result and its flags
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_ra,
  input  logic [ADDR_W-1:0] instr_rb,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] RdAdrsA,
  output logic [ADDR_W-1:0] RdAdrsB,
  input  logic [DATA_W-1:0] RdDataA,
  input  logic [DATA_W-1:0] RdDataB,
  output logic [ADDR_W-1:0] WtAdrs,
  output logic [DATA_W-1:0] WtData,
  output logic              LdReg,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c
);

  state_e            state_q;
  op_e               op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  // The read-address registers double as the latched ra/rb fields: they are
  // loaded on acceptance so the addresses are stable for the whole READ cycle.
  logic [ADDR_W-1:0] rda_q;
  logic [ADDR_W-1:0] rdb_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [ADDR_W-1:0] wta_q;
  logic [DATA_W-1:0] wtd_q;
  logic              ld_q;
  logic              done_q;
  logic [DATA_W-1:0] res_q;
  logic              z_q;
  logic              c_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  regfile_seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i     (op_q),
    .a_i      (opa_q),
    .b_i      (opb_q),
    .imm_i    (imm_q),
    .result_o (alu_res),
    .carry_o  (alu_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      imm_q   <= '0;
      rda_q   <= '0;
      rdb_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      wta_q   <= '0;
      wtd_q   <= '0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      // Write enable and done are single-cycle pulses; only EXEC raises them.
      ld_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q    <= op_e'(instr_op);
            rd_q    <= instr_rd;
            imm_q   <= instr_imm;
            rda_q   <= instr_ra;
            rdb_q   <= instr_rb;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          opa_q   <= RdDataA;
          opb_q   <= RdDataB;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q   <= alu_res;
          z_q     <= (alu_res == '0);
          c_q     <= alu_c;
          // Write-port values are registered here so that WB drives them
          // straight from flops.
          wta_q   <= rd_q;
          wtd_q   <= alu_res;
          ld_q    <= (op_q != OP_NOP);
          done_q  <= 1'b1;
          state_q <= ST_WB;
        end
        ST_WB: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign RdAdrsA     = rda_q;
  assign RdAdrsB     = rdb_q;
  assign WtAdrs      = wta_q;
  assign WtData      = wtd_q;
  assign LdReg       = ld_q;
  assign done        = done_q;
  assign result      = res_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer
// Scoreboard bench for regfile_sequencer with a behavioural 8x8 register
// file (synchronous write, combinational read).  Accepted instructions are
// queued; each done pulse pops one and compares the write port, result and
// flags against a reference model run on a shadow copy of the registers.
module tb_regfile_sequencer;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam logic [2:0] T_ADD = 3'd0;
  localparam logic [2:0] T_SUB = 3'd1;
  localparam logic [2:0] T_AND = 3'd2;
  localparam logic [2:0] T_OR  = 3'd3;
  localparam logic [2:0] T_XOR = 3'd4;
  localparam logic [2:0] T_MOV = 3'd5;
  localparam logic [2:0] T_LDI = 3'd6;
  localparam logic [2:0] T_NOP = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_ra, instr_rb;
  logic [DW-1:0] instr_imm;
  logic [AW-1:0] RdAdrsA, RdAdrsB, WtAdrs;
  logic [DW-1:0] RdDataA, RdDataB, WtData, result;
  logic          LdReg, done, flag_z, flag_c;

  regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_imm   (instr_imm),
    .RdAdrsA     (RdAdrsA),
    .RdAdrsB     (RdAdrsB),
    .RdDataA     (RdDataA),
    .RdDataB     (RdDataB),
    .WtAdrs      (WtAdrs),
    .WtData      (WtData),
    .LdReg       (LdReg),
    .done        (done),
    .result      (result),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  always #5 clk = ~clk;

  // Behavioural register file
  logic [DW-1:0] rf [8];
  logic          rf_clr;
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (LdReg) begin
      rf[WtAdrs] <= WtData;
    end
  end
  assign RdDataA = rf[RdAdrsA];
  assign RdDataB = rf[RdAdrsB];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] imm, output logic [7:0] r, output logic c);
    logic [8:0] s;
    r = 8'h00;
    c = 1'b0;
    case (op)
      T_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      T_SUB: begin r = a - b; c = (a < b); end
      T_AND: r = a & b;
      T_OR:  r = a | b;
      T_XOR: r = a ^ b;
      T_MOV: r = a;
      T_LDI: r = imm;
      default: r = 8'h00;
    endcase
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd, ra, rb;
    logic [7:0] imm;
    int         acc;
  } ins_t;

  ins_t q[$];
  logic [7:0] shadow [8];
  int  done_cnt = 0;
  int  ld_cnt = 0;
  logic stream_mode = 1'b0;

  // Monitor / scoreboard, sampling on the falling edge
  initial begin
    ins_t e;
    logic [7:0] er;
    logic ec;
    int last_acc;
    logic have_last;
    have_last = 1'b0;
    last_acc = 0;
    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        have_last = 1'b0;
      end else begin
        if (LdReg) ld_cnt++;
        if (done) begin
          done_cnt++;
          if (q.size() == 0) begin
            check_val("done_spurious", 32'(done), 32'd0);
          end else begin
            e = q.pop_front();
            model(e.op, shadow[e.ra], shadow[e.rb], e.imm, er, ec);
            check_val("latency", cyc - e.acc, 32'd2);
            check_val("ldreg_wb", 32'(LdReg), 32'(e.op != T_NOP));
            if (e.op != T_NOP) begin
              check_val("wtadrs", 32'(WtAdrs), 32'(e.rd));
              check_val("wtdata", 32'(WtData), 32'(er));
              check_val("result", 32'(result), 32'(er));
              check_val("flag_z", 32'(flag_z), 32'(er == 8'h00));
              check_val("flag_c", 32'(flag_c), 32'(ec));
              shadow[e.rd] = er;
            end
          end
        end else begin
          check_val("ldreg_idle", 32'(LdReg), 32'd0);
        end
        if (instr_valid && instr_ready) begin
          e.op = instr_op; e.rd = instr_rd; e.ra = instr_ra; e.rb = instr_rb;
          e.imm = instr_imm; e.acc = cyc + 1;
          q.push_back(e);
          if (stream_mode && have_last) check_val("spacing", e.acc - last_acc, 32'd4);
          last_acc = e.acc;
          have_last = stream_mode;
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !instr_ready; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [7:0] imm);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    wait_ready();
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    // Fields only need to be held in the accepting cycle.
    instr_op = 3'($urandom); instr_rd = 3'($urandom); instr_ra = 3'($urandom);
    instr_rb = 3'($urandom); instr_imm = 8'($urandom);
    for (int i = 0; i < 10 && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    check_val("done_seen", done_cnt - d0, 32'd1);
    @(posedge clk); #1;
  endtask

  localparam int NS = 7;
  logic [2:0] s_op  [NS] = '{T_LDI, T_ADD, T_LDI, T_AND, T_OR, T_XOR, T_MOV};
  logic [2:0] s_rd  [NS] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
  logic [2:0] s_ra  [NS] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
  logic [2:0] s_rb  [NS] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0};
  logic [7:0] s_imm [NS] = '{8'h10, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic drive_s(input int k);
    instr_op = s_op[k]; instr_rd = s_rd[k]; instr_ra = s_ra[k];
    instr_rb = s_rb[k]; instr_imm = s_imm[k];
  endtask

  task automatic run_stream();
    int idx;
    int d0;
    logic acc;
    idx = 0;
    d0 = done_cnt;
    stream_mode = 1'b1;
    @(posedge clk); #1;
    drive_s(0);
    instr_valid = 1'b1;
    for (int cy = 0; cy < 200 && idx < NS; cy++) begin
      @(negedge clk);
      acc = instr_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < NS) drive_s(idx);
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    check_val("stream_accepts", idx, NS);
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check_val("stream_dones", done_cnt - d0, NS);
    @(posedge clk); #1;
    stream_mode = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] snap [8];
    int d0, l0;
    reset = 1'b1; rf_clr = 1'b1; instr_valid = 1'b0;
    instr_op = '0; instr_rd = '0; instr_ra = '0; instr_rb = '0; instr_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(instr_ready), 32'd1);
    check_val("rst_ldreg", 32'(LdReg), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_flags", 32'({flag_z, flag_c}), 32'd0);
    check_val("rst_wt", 32'({WtAdrs, WtData}), 32'd0);
    check_val("rst_rdadrs", 32'({RdAdrsA, RdAdrsB}), 32'd0);
    reset = 1'b0; rf_clr = 1'b0;

    // Basic ADD
    issue(T_LDI, 3'd1, 3'd0, 3'd0, 8'h05);
    issue(T_LDI, 3'd2, 3'd0, 3'd0, 8'h03);
    issue(T_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    check_val("add_r3", 32'(rf[3]), 32'h08);
    check_val("add_zc", 32'({flag_z, flag_c}), 32'd0);

    // ADD wrap with carry
    issue(T_LDI, 3'd1, 3'd0, 3'd0, 8'hFF);
    issue(T_LDI, 3'd2, 3'd0, 3'd0, 8'h01);
    issue(T_ADD, 3'd4, 3'd1, 3'd2, 8'h00);
    check_val("addc_r4", 32'(rf[4]), 32'h00);
    check_val("addc_zc", 32'({flag_z, flag_c}), 32'b11);

    // SUB with borrow
    issue(T_LDI, 3'd1, 3'd0, 3'd0, 8'h03);
    issue(T_LDI, 3'd2, 3'd0, 3'd0, 8'h05);
    issue(T_SUB, 3'd5, 3'd1, 3'd2, 8'h00);
    check_val("subb_r5", 32'(rf[5]), 32'hFE);
    check_val("subb_c", 32'(flag_c), 32'd1);

    // SUB of a register from itself, destination aliases the sources
    issue(T_LDI, 3'd1, 3'd0, 3'd0, 8'h07);
    issue(T_SUB, 3'd1, 3'd1, 3'd1, 8'h00);
    check_val("subself_r1", 32'(rf[1]), 32'h00);
    check_val("subself_zc", 32'({flag_z, flag_c}), 32'b10);

    // NOP leaves the register file alone
    for (int i = 0; i < 8; i++) snap[i] = rf[i];
    l0 = ld_cnt;
    issue(T_NOP, 3'd2, 3'd1, 3'd1, 8'hAA);
    check_val("nop_ldreg", ld_cnt - l0, 32'd0);
    for (int i = 0; i < 8; i++) check_val("nop_rf", 32'(rf[i]), 32'(snap[i]));

    // Continuous valid: dependent back-to-back ops and the other ALU ops
    run_stream();
    check_val("strm_r1", 32'(rf[1]), 32'h20);
    check_val("strm_r3", 32'(rf[3]), 32'h20);
    check_val("strm_r4", 32'(rf[4]), 32'h3C);
    check_val("strm_r5", 32'(rf[5]), 32'h1C);
    check_val("strm_r7", 32'(rf[7]), 32'h3C);

    // Reset in the middle of EXEC drops the instruction
    issue(T_LDI, 3'd6, 3'd0, 3'd0, 8'h5A);
    d0 = done_cnt;
    l0 = ld_cnt;
    @(posedge clk); #1;
    wait_ready();
    instr_op = T_ADD; instr_rd = 3'd6; instr_ra = 3'd1; instr_rb = 3'd2;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_val("mrst_ready", 32'(instr_ready), 32'd1);
    check_val("mrst_ldreg", 32'(LdReg), 32'd0);
    check_val("mrst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_val("mrst_no_done", done_cnt - d0, 32'd0);
    check_val("mrst_no_ld", ld_cnt - l0, 32'd0);
    check_val("mrst_r6", 32'(rf[6]), 32'h5A);
    check_val("mrst_result", 32'(result), 32'd0);

    // Normal operation after reset
    issue(T_LDI, 3'd0, 3'd0, 3'd0, 8'h99);
    check_val("post_r0", 32'(rf[0]), 32'h99);
    check_val("post_result", 32'(result), 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
